// File: rtl/hamming_tx.sv
// hamming_tx: Hamming(7,4) encoder and bit-serial transmitter; define HAMMING_TX_ERR_INJECT_EN for inj_en/inj_pos error injection
module hamming_tx #(
  parameter int LSB_FIRST = 1,
  parameter int IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_in,
  input  logic       in_valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic       inj_en,
  input  logic [2:0] inj_pos,
`endif
  output logic       in_ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       tx_start,
  output logic       tx_done,
  output logic [6:0] code_out,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state, nxt;
  logic [2:0] cnt;
  logic [3:0] gcnt;
  logic [6:0] sr, cw, load, flip;
  logic acc, last;
  assign last = state == SHIFT && cnt == 3'd6;
  assign acc = in_valid && in_ready;
`ifdef HAMMING_TX_ERR_INJECT_EN
  assign flip = inj_en && inj_pos != 3'd0 ? 7'd1 << (inj_pos - 3'd1) : 7'd0;
`else
  assign flip = 7'd0;
`endif
  assign cw = {d_in[3:1], ^d_in[3:1], d_in[0], d_in[3] ^ d_in[2] ^ d_in[0], d_in[3] ^ d_in[1] ^ d_in[0]} ^ flip;
  // shift register is preloaded in transmit order so tx_bit is always sr[0]
  assign load = LSB_FIRST != 0 ? cw : {cw[0], cw[1], cw[2], cw[3], cw[4], cw[5], cw[6]};
  assign tx_bit = sr[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (acc ? SHIFT : IDLE)
        : state == SHIFT ? (!last || acc ? SHIFT : IDLE_GAP > 0 ? GAP : IDLE)
        : state == GAP ? (gcnt == 4'(IDLE_GAP - 1) ? IDLE : GAP)
        : IDLE;
  always_comb begin
    in_ready = state == IDLE || (IDLE_GAP == 0 && last);
    tx_valid = state == SHIFT;
    tx_start = state == SHIFT && cnt == 3'd0;
    tx_done = last;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 3'd0;
      gcnt <= 4'd0;
      sr <= 7'd0;
      code_out <= 7'd0;
    end else begin
      cnt <= acc || last ? 3'd0 : state == SHIFT ? cnt + 3'd1 : cnt;
      gcnt <= state == GAP ? gcnt + 4'd1 : 4'd0;
      sr <= acc ? load : sr >> 1;
      if (acc) code_out <= cw;
    end
endmodule

// File: tb/tb_hamming_tx.sv
// tb_hamming_tx: scoreboard bench for two hamming_tx configurations against a Hamming(7,4) reference model
module tb_hamming_tx;
  logic clk = 0, rst_n = 0;
  logic [3:0] d [2];
  logic v [2], ie [2];
  logic [2:0] ip [2];
  logic rdy [2], txb [2], tv [2], ts [2], td [2], bz [2];
  logic [6:0] co [2];
  int checks = 0, passed = 0;
  int mb [2], mg [2], wp [2], rp [2];
  logic accf [2];
  logic [6:0] mcode [2], cur [2], asm_w [2], mc;
  logic [6:0] sb [2][16];
`ifdef HAMMING_TX_ERR_INJECT_EN
  localparam bit INJ = 1;
`else
  localparam bit INJ = 0;
`endif

  always #5 clk = ~clk;

  hamming_tx #(.LSB_FIRST(1), .IDLE_GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .d_in(d[0]), .in_valid(v[0]),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .inj_en(ie[0]), .inj_pos(ip[0]),
`endif
    .in_ready(rdy[0]), .tx_bit(txb[0]), .tx_valid(tv[0]), .tx_start(ts[0]),
    .tx_done(td[0]), .code_out(co[0]), .busy(bz[0]));

  hamming_tx #(.LSB_FIRST(0), .IDLE_GAP(3)) u1 (
    .clk(clk), .rst_n(rst_n), .d_in(d[1]), .in_valid(v[1]),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .inj_en(ie[1]), .inj_pos(ip[1]),
`endif
    .in_ready(rdy[1]), .tx_bit(txb[1]), .tx_valid(tv[1]), .tx_start(ts[1]),
    .tx_done(td[1]), .code_out(co[1]), .busy(bz[1]));

  function automatic int gap(input int i);
    return i == 0 ? 0 : 3;
  endfunction

  function automatic bit lsbf(input int i);
    return i == 0;
  endfunction

  function automatic logic mrdy(input int i);
    return (mb[i] == 0 && mg[i] == 0) || (gap(i) == 0 && mb[i] == 1);
  endfunction

  // data fills the non-power-of-two positions; parity at position p covers every position with bit p set
  function automatic logic [6:0] enc(input logic [3:0] dv);
    logic [6:0] c;
    int k;
    c = 7'd0;
    k = 0;
    for (int pos = 1; pos <= 7; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = dv[k];
        k++;
      end
    for (int p = 1; p <= 4; p = p * 2)
      for (int pos = 1; pos <= 7; pos++)
        if ((pos & p) != 0 && pos != p) c[p-1] = c[p-1] ^ c[pos-1];
    return c;
  endfunction

  task automatic chk1(input string nm, input int i, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %b expected %b", nm, i, act, exp);
  endtask

  task automatic chk7(input string nm, input int i, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %b expected %b", nm, i, act, exp);
  endtask

  // cycle model: mb = frame bits still to show (7 means first bit this cycle), mg = gap cycles left
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mb[i] = 0; mg[i] = 0; wp[i] = 0; rp[i] = 0; accf[i] = 0; mcode[i] = 7'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        accf[i] = v[i] && mrdy(i);
        if (accf[i]) begin
          mc = enc(d[i]);
          if (INJ && ie[i] && ip[i] != 3'd0) mc[ip[i]-1] = ~mc[ip[i]-1];
          mcode[i] = mc;
          sb[i][wp[i] % 16] = mc;
          wp[i]++;
          mb[i] = 7;
        end else if (mb[i] > 0) begin
          mb[i]--;
          if (mb[i] == 0) mg[i] = gap(i);
        end else if (mg[i] > 0) mg[i]--;
      end
    end

  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < 2; i++) begin
        chk1("in_ready", i, rdy[i], mrdy(i));
        chk1("tx_valid", i, tv[i], mb[i] > 0);
        chk1("tx_start", i, ts[i], mb[i] == 7);
        chk1("tx_done", i, td[i], mb[i] == 1);
        chk1("busy", i, bz[i], mb[i] > 0 || mg[i] > 0);
        chk7("code_out", i, co[i], mcode[i]);
        if (mb[i] == 7) begin
          cur[i] = sb[i][rp[i] % 16];
          rp[i]++;
        end
        if (mb[i] > 0) asm_w[i][lsbf(i) ? 7 - mb[i] : mb[i] - 1] = txb[i];
        else chk1("idle_bit", i, txb[i], 1'b0);
        if (mb[i] == 1) chk7("frame", i, asm_w[i], cur[i]);
      end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [3:0] dv, input logic keep);
    bit got;
    got = 0;
    v[i] = 1;
    d[i] = dv;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk);
      #1;
      got = accf[i];
    end
    if (!got) begin
      checks++;
      $display("FAIL accept_timeout[%0d]: got no accept, expected one within 60 cycles", i);
    end
    v[i] = keep;
    d[i] = 4'($urandom);
  endtask

  task automatic run(input int i);
    ie[i] = 0;
    ip[i] = 0;
    send(i, 4'b1011, 0);
    chk7("code_1011", i, co[i], 7'b1010101);
    idle(12);
    for (int n = 0; n < 16; n++) begin
      send(i, 4'(n), 0);
      if (n == 0) chk7("code_0000", i, co[i], 7'b0000000);
      if (n == 1) chk7("code_0001", i, co[i], 7'b0000111);
      if (n == 15) chk7("code_1111", i, co[i], 7'b1111111);
      idle($urandom_range(0, 9));
    end
    idle(12);
    send(i, 4'b0001, 1);
    send(i, 4'b1111, 0);
    idle(20);
`ifdef HAMMING_TX_ERR_INJECT_EN
    ie[i] = 1;
    ip[i] = 3;
    send(i, 4'b1011, 0);
    chk7("inj_pos3", i, co[i], 7'b1010001);
    ip[i] = 0;
    send(i, 4'b1011, 0);
    chk7("inj_pos0", i, co[i], 7'b1010101);
    ie[i] = 0;
    idle(12);
`endif
    for (int k = 0; k < 300; k++) begin
      v[i] = $urandom_range(0, 3) != 0;
      d[i] = 4'($urandom);
      if (INJ) begin
        ie[i] = 1'($urandom);
        ip[i] = 3'($urandom);
      end
      @(posedge clk);
      #1;
    end
    v[i] = 0;
    ie[i] = 0;
    idle(20);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; d[i] = 4'd0; ie[i] = 0; ip[i] = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1("rst_in_ready", i, rdy[i], 1'b1);
      chk1("rst_tx_valid", i, tv[i], 1'b0);
      chk1("rst_tx_start", i, ts[i], 1'b0);
      chk1("rst_tx_done", i, td[i], 1'b0);
      chk1("rst_tx_bit", i, txb[i], 1'b0);
      chk1("rst_busy", i, bz[i], 1'b0);
      chk7("rst_code_out", i, co[i], 7'd0);
    end
    rst_n = 1;
    idle(1);
    fork
      run(0);
      run(1);
    join
    for (int i = 0; i < 2; i++) begin
      v[i] = 1;
      d[i] = 4'b1011;
    end
    idle(1);
    for (int i = 0; i < 2; i++) v[i] = 0;
    for (int k = 0; k < 20 && mb[0] != 4; k++) idle(1);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1("mid_rst_tx_valid", i, tv[i], 1'b0);
      chk1("mid_rst_tx_bit", i, txb[i], 1'b0);
      chk1("mid_rst_in_ready", i, rdy[i], 1'b1);
      chk7("mid_rst_code_out", i, co[i], 7'd0);
    end
    @(posedge clk);
    #2 rst_n = 1;
    idle(1);
    fork
      send(0, 4'b0110, 0);
      send(1, 4'b0110, 0);
    join
    idle(20);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end before 100000 time units");
    $fatal(1);
  end
endmodule
